rv32i_dmem_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: port 0 = rv32i core

---
 rtl/rv32i_dmem_arbiter_if.sv | 23 ++
 rtl/rv32i_dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_rv32i_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_dmem_arbiter_if.sv
// Requester-side bus of the data-RAM arbiter: one instance per requester.
interface rv32i_dmem_arbiter_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Requester drives the access, arbiter answers with grant and read response.
  modport master (
    output req, wr, addr, wdata, wmask,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, wr, addr, wdata, wmask,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/rv32i_dmem_arbiter.sv
// Data-RAM arbiter: port 0 = core LSU, port 1 = loader/DMA.
// Per-cycle round-robin, with a bounded burst lock that port 1 may hold
// for at most MAX_BURST consecutive grants while the core is waiting.
module rv32i_dmem_arbiter #(
  parameter int unsigned RAM_BYTES = 8192,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32i_dmem_arbiter_if.slave  p0_bus,
  rv32i_dmem_arbiter_if.slave  p1_bus,
  input  logic                 p1_lock_i,
  output logic [31:0]          ram_addr_o,
  output logic                 ram_wr_en_o,
  output logic [31:0]          ram_data_in_o,
  output logic [3:0]           ram_wr_mask_o,
  output logic                 ram_rd_en_o,
  input  logic [31:0]          ram_data_out_i
);

  localparam int unsigned      CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [31:0]      ADDR_LIMIT = 32'(RAM_BYTES);

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_gnt_q, last_gnt_d;   // port that received the most recent grant
  logic             gnt0, gnt1;

  logic             rd_pend_q;                // a read response is due this cycle
  logic             rd_owner_q;               // which port that response belongs to
  logic             rd_oor_q;                 // response comes from an out-of-range read
  logic             err0_q, err1_q;

  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wmask;
  logic             sel_wr;
  logic             in_range;
  logic [31:0]      rd_data;

  // State register plus the read-response and error pipeline.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_gnt_q  <= 1'b1;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_gnt_q  <= last_gnt_d;
      rd_pend_q   <= (gnt0 & ~p0_bus.wr) | (gnt1 & ~p1_bus.wr);
      rd_owner_q  <= gnt1;
      rd_oor_q    <= ~in_range;
      err0_q      <= gnt0 & ~in_range;
      err1_q      <= gnt1 & ~in_range;
    end
  end

  // Grant decision and next state: burst continuation while locked, else round-robin.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_gnt_d  = last_gnt_q;
    if (state_q == LOCK1 && p1_bus.req && p1_lock_i) begin
      if (burst_cnt_q < BURST_MAX) begin
        gnt1        = 1'b1;
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end else if (p0_bus.req) begin
        // Burst budget spent and the core is waiting: hand over and unlock.
        gnt0        = 1'b1;
        state_d     = IDLE;
        burst_cnt_d = '0;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      // Unlocked, or the lock was released this cycle: plain round-robin.
      state_d     = IDLE;
      burst_cnt_d = '0;
      if (p0_bus.req && p1_bus.req) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = p0_bus.req;
        gnt1 = p1_bus.req;
      end
      if (gnt1 && p1_lock_i) begin
        state_d     = LOCK1;
        burst_cnt_d = CNT_W'(1);
      end
    end
    if (gnt0) begin
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
    end
  end

  // RAM side: route the granted port to the RAM in the same cycle.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_wr    = 1'b0;
    if (gnt0) begin
      sel_addr  = p0_bus.addr;
      sel_wdata = p0_bus.wdata;
      sel_wmask = p0_bus.wmask;
      sel_wr    = p0_bus.wr;
    end else if (gnt1) begin
      sel_addr  = p1_bus.addr;
      sel_wdata = p1_bus.wdata;
      sel_wmask = p1_bus.wmask;
      sel_wr    = p1_bus.wr;
    end
    in_range      = sel_addr < ADDR_LIMIT;
    ram_addr_o    = sel_addr;
    ram_data_in_o = sel_wdata;
    ram_wr_mask_o = sel_wmask;
    ram_wr_en_o   = (gnt0 | gnt1) & sel_wr & in_range;
    ram_rd_en_o   = (gnt0 | gnt1) & ~sel_wr & in_range;
  end

  // Out-of-range reads still complete, returning zero instead of stale RAM output.
  assign rd_data = rd_oor_q ? 32'h0 : ram_data_out_i;

  assign p0_bus.gnt    = gnt0;
  assign p1_bus.gnt    = gnt1;
  assign p0_bus.rvalid = rd_pend_q & ~rd_owner_q;
  assign p1_bus.rvalid = rd_pend_q & rd_owner_q;
  assign p0_bus.rdata  = p0_bus.rvalid ? rd_data : 32'h0;
  assign p1_bus.rdata  = p1_bus.rvalid ? rd_data : 32'h0;
  assign p0_bus.err    = err0_q;
  assign p1_bus.err    = err1_q;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Bench for rv32i_dmem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model and a RAM model.
module tb_rv32i_dmem_arbiter;
  localparam int unsigned RAM_BYTES = 8192;
  localparam int unsigned MAX_BURST = 8;

  typedef struct {
    bit          req;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p1_lock = 1'b0;
  logic [31:0] ram_addr;
  logic        ram_wr_en;
  logic [31:0] ram_data_in;
  logic [3:0]  ram_wr_mask;
  logic        ram_rd_en;
  logic [31:0] ram_data_out = 32'h0;

  rv32i_dmem_arbiter_if p0_if ();
  rv32i_dmem_arbiter_if p1_if ();

  always #5 clk = ~clk;

  rv32i_dmem_arbiter #(.RAM_BYTES(RAM_BYTES), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p0_bus        (p0_if.slave),
    .p1_bus        (p1_if.slave),
    .p1_lock_i     (p1_lock),
    .ram_addr_o    (ram_addr),
    .ram_wr_en_o   (ram_wr_en),
    .ram_data_in_o (ram_data_in),
    .ram_wr_mask_o (ram_wr_mask),
    .ram_rd_en_o   (ram_rd_en),
    .ram_data_out_i(ram_data_out)
  );

  // Behavioural RAM that the arbiter drives.
  logic [31:0] tb_mem  [0:2047];
  // Reference memory: what the data should be if every granted write landed correctly.
  logic [31:0] ref_mem [0:2047];

  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_mask[b]) tb_mem[ram_addr[12:2]][8*b +: 8] <= ram_data_in[8*b +: 8];
    if (ram_rd_en) ram_data_out <= tb_mem[ram_addr[12:2]];
  end

  int errors = 0;
  int checks = 0;

  // Reference model state: who owns the tie-break, and length of the current locked run.
  int          mdl_last;
  int          mdl_run;
  bit          mdl_locked;
  bit          exp_rv  [2];
  bit          exp_err [2];
  logic [31:0] exp_rd  [2];

  req_t idle_req = '{req: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0, mask: 4'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    mdl_last   = 1;
    mdl_run    = 0;
    mdl_locked = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p]  = 1'b0;
      exp_err[p] = 1'b0;
      exp_rd[p]  = 32'h0;
    end
  endtask

  task automatic drive(input req_t q0, input req_t q1, input bit lk);
    p0_if.req = q0.req; p0_if.wr = q0.wr; p0_if.addr = q0.addr;
    p0_if.wdata = q0.wdata; p0_if.wmask = q0.mask;
    p1_if.req = q1.req; p1_if.wr = q1.wr; p1_if.addr = q1.addr;
    p1_if.wdata = q1.wdata; p1_if.wmask = q1.mask;
    p1_lock = lk;
  endtask

  // One bus cycle: entered at a falling edge, drives requests, checks the
  // combinational grant/RAM side, then checks the registered response at the next falling edge.
  task automatic cycle(input req_t q0, input req_t q1, input bit lk, output bit g0, output bit g1);
    int          eg;
    req_t        sel;
    bit          in_rng;
    logic [10:0] idx;
    drive(q0, q1, lk);
    #1;
    g0 = p0_if.gnt;
    g1 = p1_if.gnt;
    // Expected owner: a locked run keeps port 1 until its budget is spent and the core waits.
    if (mdl_locked && q1.req && lk)
      eg = (mdl_run >= int'(MAX_BURST) && q0.req) ? 0 : 1;
    else if (q0.req && q1.req)
      eg = 1 - mdl_last;
    else if (q0.req)
      eg = 0;
    else if (q1.req)
      eg = 1;
    else
      eg = -1;
    check("gnt0", g0, eg == 0);
    check("gnt1", g1, eg == 1);
    sel    = (eg == 1) ? q1 : q0;
    in_rng = sel.addr < RAM_BYTES;
    idx    = sel.addr[12:2];
    if (eg < 0) begin
      check("idle_ram_addr", ram_addr, 32'h0);
      check("idle_wr_en", ram_wr_en, 0);
      check("idle_rd_en", ram_rd_en, 0);
    end else begin
      check("ram_addr", ram_addr, sel.addr);
      check("ram_wr_en", ram_wr_en, sel.wr && in_rng);
      check("ram_rd_en", ram_rd_en, !sel.wr && in_rng);
      if (sel.wr && in_rng) begin
        check("ram_data_in", ram_data_in, sel.wdata);
        check("ram_wr_mask", ram_wr_mask, sel.mask);
        ref_mem[idx] = merge(ref_mem[idx], sel.wdata, sel.mask);
      end
    end
    for (int p = 0; p < 2; p++) begin
      exp_rv[p]  = (eg == p) && !sel.wr;
      exp_err[p] = (eg == p) && !in_rng;
      exp_rd[p]  = in_rng ? ref_mem[idx] : 32'h0;
    end
    if (eg >= 0) mdl_last = eg;
    if (eg == 1 && lk) begin
      mdl_run    = mdl_locked ? ((mdl_run < int'(MAX_BURST)) ? mdl_run + 1 : mdl_run) : 1;
      mdl_locked = 1'b1;
    end else begin
      mdl_run    = 0;
      mdl_locked = 1'b0;
    end
    @(negedge clk);
    check("p0_rvalid", p0_if.rvalid, exp_rv[0]);
    check("p1_rvalid", p1_if.rvalid, exp_rv[1]);
    check("p0_err", p0_if.err, exp_err[0]);
    check("p1_err", p1_if.err, exp_err[1]);
    if (exp_rv[0]) check("p0_rdata", p0_if.rdata, exp_rd[0]);
    if (exp_rv[1]) check("p1_rdata", p1_if.rdata, exp_rd[1]);
  endtask

  task automatic do_reset();
    drive(idle_req, idle_req, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_p0_rvalid", p0_if.rvalid, 0);
    check("rst_p1_rvalid", p1_if.rvalid, 0);
    check("rst_p0_err", p0_if.err, 0);
    check("rst_p1_err", p1_if.err, 0);
    check("rst_p0_rdata", p0_if.rdata, 32'h0);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_gnt", {p0_if.gnt, p1_if.gnt}, 0);
    @(negedge clk);
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.req   = 1'b1;
    r.wr    = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 11) == 0)
      r.addr = RAM_BYTES + ($urandom_range(0, 255) << 2);
    else
      r.addr = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
    r.wdata = $urandom;
    r.mask  = 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    req_t q0, q1, a0, a1;
    bit   g0, g1, lk;
    int   n1, c, p0_gc, run_before;

    for (int i = 0; i < 2048; i++) begin
      tb_mem[i]  = 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_reset();
    do_reset();

    // Core write then read-back of the same word.
    q0 = '{req: 1'b1, wr: 1'b1, addr: 32'h1000, wdata: 32'h12345678, mask: 4'hF};
    cycle(q0, idle_req, 1'b0, g0, g1);
    check("t1_wr_gnt", g0, 1);
    q0.wr = 1'b0;
    cycle(q0, idle_req, 1'b0, g0, g1);
    check("t1_rvalid", p0_if.rvalid, 1);
    check("t1_rdata", p0_if.rdata, 32'h12345678);

    // Both ports requesting, no lock: strict alternation starting at port 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0 = '{req: 1'b1, wr: 1'b0, addr: 32'(i * 8), wdata: 32'h0, mask: 4'h0};
      q1 = '{req: 1'b1, wr: 1'b0, addr: 32'(32'h100 + i * 4), wdata: 32'h0, mask: 4'h0};
      cycle(q0, q1, 1'b0, g0, g1);
      check("t2_alternate", g0, (i % 2) == 0);
    end

    // Locked loader burst of 12 writes; the core starts waiting at cycle 2.
    do_reset();
    n1 = 0; c = 0; p0_gc = -1; run_before = -1;
    while (n1 < 12 && c < 40) begin
      q1 = '{req: 1'b1, wr: 1'b1, addr: 32'(32'h200 + n1 * 4), wdata: $urandom, mask: 4'hF};
      q0 = '{req: (c >= 2 && p0_gc < 0), wr: 1'b1, addr: 32'h300, wdata: 32'hCAFE0001, mask: 4'hF};
      cycle(q0, q1, 1'b1, g0, g1);
      if (g1) n1++;
      if (g0) begin
        p0_gc      = c;
        run_before = n1;
      end
      c++;
    end
    check("t3_p1_run", run_before, MAX_BURST);
    check("t3_p0_wait", p0_gc - 2 + 1, 7);
    check("t3_p1_total", n1, 12);

    // Out-of-range loader read.
    q1 = '{req: 1'b1, wr: 1'b0, addr: 32'h2000, wdata: 32'h0, mask: 4'h0};
    cycle(idle_req, q1, 1'b0, g0, g1);
    check("t4_err", p1_if.err, 1);
    check("t4_rvalid", p1_if.rvalid, 1);
    check("t4_rdata", p1_if.rdata, 32'h0);

    // Reset pulse between a read grant and its response.
    q0 = '{req: 1'b1, wr: 1'b0, addr: 32'h40, wdata: 32'h0, mask: 4'h0};
    drive(q0, idle_req, 1'b0);
    #1;
    check("t5_gnt", p0_if.gnt, 1);
    p0_if.req = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("t5_no_rvalid", p0_if.rvalid, 0);
    q1 = '{req: 1'b1, wr: 1'b0, addr: 32'h44, wdata: 32'h0, mask: 4'h0};
    cycle(q0, q1, 1'b0, g0, g1);
    check("t5_tie_p0", g0, 1);

    // Lock released while the core waits: core wins that very cycle.
    do_reset();
    q0 = '{req: 1'b1, wr: 1'b1, addr: 32'h500, wdata: 32'hA5A5A5A5, mask: 4'h3};
    q1 = '{req: 1'b1, wr: 1'b1, addr: 32'h600, wdata: 32'h5A5A5A5A, mask: 4'hC};
    cycle(idle_req, q1, 1'b1, g0, g1);
    cycle(q0, q1, 1'b1, g0, g1);
    cycle(q0, q1, 1'b1, g0, g1);
    check("t6_locked", g1, 1);
    cycle(q0, q1, 1'b0, g0, g1);
    check("t6_p0_on_unlock", g0, 1);
    cycle(idle_req, q1, 1'b1, g0, g1);
    check("t6_p1_after", g1, 1);

    // Random traffic; requests are held until granted.
    do_reset();
    a0 = idle_req;
    a1 = idle_req;
    lk = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!a0.req && $urandom_range(0, 3) != 0) a0 = rnd_req();
      if (!a1.req && $urandom_range(0, 7) != 0) a1 = rnd_req();
      if ($urandom_range(0, 9) == 0) lk = !lk;
      cycle(a0, a1, lk, g0, g1);
      if (g0) a0.req = 1'b0;
      if (g1) a1.req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
